mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Load/store initiator between the MEM pipeline stage and the word-wide data memory, which is a single-port responder: combinational read, write on the clock edge, indexed by word.
- Accepts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests over a valid/ready handshake.
- Drives the memory's word address, write data and write enable.
- Returns aligned, sign/zero-extended load data.
- Performs sub-word stores as a two-cycle read-modify-write and flags misaligned and out-of-range accesses.

Parameters:
DEPTH, 100, number of 32-bit words in the data memory; valid word indices are 0..DEPTH-1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request; high only in IDLE.
req_op  input  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW.
req_addr  input  32  byte address.
req_wdata  input  32  store data; the SB/SH payload is in the low bits.
rsp_valid  output  1  one-cycle completion pulse, for loads, stores and faults.
rsp_rdata  output  32  load result; 0 for stores and faults.
rsp_fault  output  2  00 ok, 01 misaligned, 10 out of range.
mem_addr  output  32  word index, req_addr[31:2] of the latched request.
mem_wdata  output  32  word written to memory.
mem_we  output  1  memory write enable.
mem_rdata  input  32  combinational memory read data.

Behaviour:
- Byte lanes are little-endian: byte offset k occupies bits [8k+7:8k]; halfword offset 2 occupies [31:16].
- States: IDLE, ACCESS, WRITE, FAULT.
- Handshake: a request is accepted on a rising edge with req_valid and req_ready both high. Op, address and wdata are latched on acceptance; request inputs are ignored at all other times.
- Fault check at acceptance:
  - Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Out of range: addr[31:2] >= DEPTH.
  - Misaligned takes priority over out of range.
  - A faulting request goes to FAULT, otherwise to ACCESS.
- FAULT (1 cycle):
  - mem_we=0, no memory access.
  - On exit, rsp_valid=1, rsp_fault=code, rsp_rdata=0; state goes to IDLE.
- ACCESS (1 cycle):
  - mem_addr = latched word index.
  - Loads: the selected byte/halfword/word of mem_rdata is extended (LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged) and registered into rsp_rdata. rsp_valid=1 next cycle; go to IDLE.
  - SW: mem_we=1 with mem_wdata=latched wdata during this cycle; rsp_valid=1 next cycle; go to IDLE.
  - SB/SH: mem_rdata is captured, the selected lane is replaced with wdata[7:0] or wdata[15:0], and the merged word is held; go to WRITE.
- WRITE (1 cycle): mem_we=1, mem_wdata=merged word; rsp_valid=1 next cycle; go to IDLE.
- Latency from the accept edge to the rsp_valid cycle:
  - Loads, SW and faults: 2 cycles (rsp_valid high in the cycle after the second edge).
  - SB/SH: 3 cycles.
- Throughput: rsp_valid and req_ready may be high together, so a new request can be accepted in the response cycle.
- mem_addr, mem_wdata and mem_we are decoded combinationally from state and latched registers. In IDLE and FAULT they are 0.
- rsp_valid is a single-cycle pulse. rsp_rdata and rsp_fault hold their last values until the next response.
- Reset (reset=0), asynchronous and effective at any time:
  - State goes to IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_fault=00; latched request cleared.
  - mem_we deasserts immediately.
  - A reset during ACCESS or WRITE aborts the operation: no write edge occurs and the memory word is unchanged.
  - req_ready=1 from the first cycle after reset releases.
- Write address is the latched index only; mem_we is never asserted for an index >= DEPTH.

Test Plan:
1. Hold reset low 3 cycles, then release -> req_ready=1, rsp_valid=0, mem_we=0, rsp_rdata=0, rsp_fault=00.
2. SW addr 0x10 data 0xDEADBEEF -> mem_we high one cycle with mem_addr=4, mem_wdata=0xDEADBEEF, then rsp_valid with rsp_fault=00. Then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_valid 2 cycles after accept.
3. SB 0x11 data 0x000000A5 over word 0xDEADBEEF -> ACCESS has mem_we=0; WRITE has mem_we=1, mem_wdata=0xDEADA5EF; rsp_valid 3 cycles after accept. LB 0x11 -> 0xFFFFFFA5; LBU 0x11 -> 0x000000A5.
4. SH 0x12 data 0x00001234 -> word becomes 0x1234A5EF. LH 0x12 -> 0x00001234; LHU 0x12 -> 0x00001234; LH 0x10 -> 0xFFFFA5EF.
5. Faults:
   - LW 0x13 -> rsp_fault=01, rsp_rdata=0, no mem_we.
   - SW 0x190 (word 100) -> rsp_fault=10, memory untouched.
   - LH 0x191 -> rsp_fault=01 (misaligned priority).
   - Back-to-back: a new request accepted in the rsp_valid cycle completes normally.
6. SH 0x10 data 0xFFFF; pull reset low mid-cycle during WRITE -> mem_we falls asynchronously, word 4 stays 0x1234A5EF (verify with LW after release), rsp_valid never pulses, req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store initiator between the MEM stage and a
// single-port word memory (combinational read, write on clock edge).
// Handles byte/halfword/word loads with extension, sub-word stores as a
// read-modify-write, and reports misaligned / out-of-range faults.
module mem_access_ctrl #(
    parameter int DEPTH = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, FAULT} state_t;
    typedef enum logic [2:0] {
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
    } op_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      state;
    op_t         op;
    op_t         req_op_e;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] merged;
    logic [1:0]  fault;

    logic [1:0]  req_fault;
    logic [4:0]  lane_shift;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic        is_store;
    logic        is_sub_store;
    logic [31:0] word_index;

    assign req_op_e     = op_t'(req_op);
    assign req_ready    = (state == IDLE);
    assign lane_shift   = {addr[1:0], 3'b000};
    assign shifted      = mem_rdata >> lane_shift;
    assign is_store     = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    assign is_sub_store = (op == OP_SB) || (op == OP_SH);
    assign word_index   = {2'b00, addr[31:2]};

    // Fault classification of the incoming request; misalignment wins.
    always_comb begin
        req_fault = 2'b00;
        if (((req_op_e == OP_LH || req_op_e == OP_LHU || req_op_e == OP_SH) && req_addr[0]) ||
            ((req_op_e == OP_LW || req_op_e == OP_SW) && (req_addr[1:0] != 2'b00)))
            req_fault = 2'b01;
        else if ({2'b00, req_addr[31:2]} >= DEPTH_W)
            req_fault = 2'b10;
    end

    // Lane extraction and extension of the memory word for loads.
    always_comb begin
        load_data = '0;
        case (op)
            OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_data = {24'h000000, shifted[7:0]};
            OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_data = {16'h0000, shifted[15:0]};
            OP_LW:   load_data = mem_rdata;
            default: load_data = '0;
        endcase
    end

    // Lane replacement for sub-word stores (read part of the RMW).
    always_comb begin
        merge_data = mem_rdata;
        if (op == OP_SB)
            merge_data = (mem_rdata & ~(32'h0000_00FF << lane_shift)) |
                         ({24'h000000, wdata[7:0]} << lane_shift);
        else if (op == OP_SH)
            merge_data = (mem_rdata & ~(32'h0000_FFFF << lane_shift)) |
                         ({16'h0000, wdata[15:0]} << lane_shift);
    end

    // Memory port decode; only ACCESS and WRITE touch the memory, and both
    // are reached only by requests that passed the range check.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (state)
            ACCESS: begin
                mem_addr = word_index;
                if (op == OP_SW) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata;
                end
            end
            WRITE: begin
                mem_addr  = word_index;
                mem_we    = 1'b1;
                mem_wdata = merged;
            end
            default: ;
        endcase
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op        <= OP_LB;
            addr      <= '0;
            wdata     <= '0;
            merged    <= '0;
            fault     <= 2'b00;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 2'b00;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op    <= req_op_e;
                        addr  <= req_addr;
                        wdata <= req_wdata;
                        fault <= req_fault;
                        state <= (req_fault != 2'b00) ? FAULT : ACCESS;
                    end
                end
                FAULT: begin
                    rsp_valid <= 1'b1;
                    rsp_fault <= fault;
                    rsp_rdata <= '0;
                    state     <= IDLE;
                end
                ACCESS: begin
                    if (is_sub_store) begin
                        merged <= merge_data;
                        state  <= WRITE;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_fault <= 2'b00;
                        rsp_rdata <= is_store ? 32'h0 : load_data;
                        state     <= IDLE;
                    end
                end
                WRITE: begin
                    rsp_valid <= 1'b1;
                    rsp_fault <= 2'b00;
                    rsp_rdata <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: word memory responder plus a
// transaction-level reference model; directed plan items then random traffic.
module tb_mem_access_ctrl;

    localparam int DEPTH = 100;
    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3,
                           LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        preload = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_ctrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_fault (rsp_fault),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory responder: combinational read, write on rising edge.
    assign mem_rdata = (mem_addr < 32'(DEPTH)) ? mem[mem_addr[6:0]] : 32'h0;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
        end else if (mem_we && mem_addr < 32'(DEPTH)) begin
            mem[mem_addr[6:0]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: resolves one request from the architectural rules and
    // updates the reference memory image for successful stores.
    task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic [1:0] flt,
                         output int lat, output int we_lat, output logic [31:0] new_word);
        int unsigned idx, off;
        logic [31:0] w, b, h;
        idx = addr >> 2;
        off = addr % 4;
        rd = 0; flt = 0; we_lat = 0; new_word = 0; lat = 2;
        if (((op == LH || op == LHU || op == SH) && (addr % 2 == 1)) ||
            ((op == LW || op == SW) && off != 0))
            flt = 2'b01;
        else if (idx >= DEPTH)
            flt = 2'b10;
        if (flt != 0) return;
        w = ref_mem[idx];
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (8 * off)) & 32'hFFFF;
        case (op)
            LB:  rd = (b >= 128) ? b + 32'hFFFFFF00 : b;
            LBU: rd = b;
            LH:  rd = (h >= 32768) ? h + 32'hFFFF0000 : h;
            LHU: rd = h;
            LW:  rd = w;
            SW: begin new_word = wd; we_lat = 1; end
            SB: begin
                new_word = (w & ~(32'hFF << (8 * off))) | ((wd & 32'hFF) << (8 * off));
                we_lat = 2; lat = 3;
            end
            default: begin
                new_word = (w & ~(32'hFFFF << (8 * off))) | ((wd & 32'hFFFF) << (8 * off));
                we_lat = 2; lat = 3;
            end
        endcase
        if (we_lat != 0) ref_mem[idx] = new_word;
    endtask

    // Issue one request at a falling edge and follow it to its response.
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] e_rd, e_word, we_addr, we_data;
        logic [1:0]  e_flt;
        int e_lat, e_we_lat, lat, n_we, we_lat;
        bit done;
        model(op, addr, wd, e_rd, e_flt, e_lat, e_we_lat, e_word);
        check("req_ready", {31'b0, req_ready}, 1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 0; n_we = 0; we_lat = 0; we_addr = 0; we_data = 0; done = 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
            if (mem_we) begin
                n_we++; we_lat = lat; we_addr = mem_addr; we_data = mem_wdata;
            end
            if (rsp_valid) done = 1;
        end
        check("rsp_timeout", {31'b0, done}, 1);
        check("latency", lat, e_lat);
        check("rsp_rdata", rsp_rdata, e_rd);
        check("rsp_fault", {30'b0, rsp_fault}, {30'b0, e_flt});
        check("we_count", n_we, (e_we_lat != 0) ? 1 : 0);
        if (e_we_lat != 0) begin
            check("we_cycle", we_lat, e_we_lat);
            check("we_addr", we_addr, addr >> 2);
            check("we_data", we_data, e_word);
        end
        check("ready_in_rsp", {31'b0, req_ready}, 1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;

        // 1: reset for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 1);
        check("rst_valid", {31'b0, rsp_valid}, 0);
        check("rst_we", {31'b0, mem_we}, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_fault", {30'b0, rsp_fault}, 0);

        // 2-4: word, byte and halfword traffic on word 4
        do_req(SW, 32'h10, 32'hDEADBEEF);
        do_req(LW, 32'h10, 32'h0);
        check("lw_const", rsp_rdata, 32'hDEADBEEF);
        do_req(SB, 32'h11, 32'h000000A5);
        check("sb_word", ref_mem[4], 32'hDEADA5EF);
        do_req(LB, 32'h11, 32'h0);
        check("lb_const", rsp_rdata, 32'hFFFFFFA5);
        do_req(LBU, 32'h11, 32'h0);
        do_req(SH, 32'h12, 32'h00001234);
        do_req(LH, 32'h12, 32'h0);
        do_req(LHU, 32'h12, 32'h0);
        do_req(LH, 32'h10, 32'h0);
        check("lh_const", rsp_rdata, 32'hFFFFA5EF);

        // 5: faults, back-to-back with normal requests
        do_req(LW, 32'h13, 32'h0);
        do_req(SW, 32'h190, 32'h12345678);
        do_req(LH, 32'h191, 32'h0);
        do_req(LW, 32'h10, 32'h0);

        // 6: reset during the WRITE cycle of a halfword store
        req_valid = 1'b1; req_op = SH; req_addr = 32'h10; req_wdata = 32'h0000FFFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_we_before", {31'b0, mem_we}, 1);
        #2 reset = 1'b0;
        #1 check("abort_we_async", {31'b0, mem_we}, 0);
        repeat (2) begin
            @(negedge clk);
            check("abort_no_rsp", {31'b0, rsp_valid}, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready", {31'b0, req_ready}, 1);
        check("abort_no_rsp2", {31'b0, rsp_valid}, 0);
        check("abort_rdata", rsp_rdata, 0);
        do_req(LW, 32'h10, 32'h0);
        check("abort_word", rsp_rdata, 32'h1234A5EF);

        // Random traffic, mostly in range, occasional idle gaps
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 3) != 0)
                a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(0, 3));
            else
                a = 32'($urandom_range(0, 32'h1FF));
            do_req(3'($urandom_range(0, 7)), a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check("rsp_pulse", {31'b0, rsp_valid}, 0);
            end
        end

        for (int i = 0; i < DEPTH; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
